// File: rtl/jt10_adpcmb_fetch.sv
// ADPCM-B sample fetch front end: walks ROM bytes between start/end pages, splits them into
// nibbles (high first) and paces the decoder's adv strobe from a Delta-N phase accumulator.
module jt10_adpcmb_fetch #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          start,
    input  logic          stop,
    input  logic          repeat_en,
    input  logic [15:0]   start_page,
    input  logic [15:0]   end_page,
    input  logic [15:0]   delta_n,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    data,
    output logic          adv,
    output logic          chon,
    output logic          flag_end,
    output logic          underrun
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   ptr, ptr_nx, rom_addr_nx;
    logic            rom_cs_nx;
    logic [7:0]      cur, cur_nx, nxt, nxt_nx;
    logic            cur_valid, cur_valid_nx, nxt_valid, nxt_valid_nx;
    logic            cur_end, cur_end_nx, nxt_end, nxt_end_nx;
    logic            nib, nib_nx;
    logic [15:0]     phase, phase_nx;
    logic            fetch_stop, fetch_stop_nx;
    logic            chon_nx, underrun_nx, adv_nx, flag_end_nx;
    logic            finish, got, byte_is_end;
    logic [16:0]     acc_sum;
    logic [AW-1:0]   start_byte, end_byte, ptr_inc;

    assign start_byte  = AW'({start_page, 8'h00});
    assign end_byte    = AW'({end_page, 8'hFF});
    assign acc_sum     = {1'b0, phase} + {1'b0, delta_n};
    assign got         = rom_cs & rom_ok;
    assign byte_is_end = (rom_addr == end_byte);
    assign ptr_inc     = (ptr == end_byte) ? start_byte : ptr + AW'(1);
    assign data        = nib ? cur[3:0] : cur[7:4];

    always_comb begin
        state_nx      = state;
        ptr_nx        = ptr;
        rom_addr_nx   = rom_addr;
        rom_cs_nx     = rom_cs;
        cur_nx        = cur;
        nxt_nx        = nxt;
        cur_valid_nx  = cur_valid;
        nxt_valid_nx  = nxt_valid;
        cur_end_nx    = cur_end;
        nxt_end_nx    = nxt_end;
        nib_nx        = nib;
        phase_nx      = phase;
        fetch_stop_nx = fetch_stop;
        chon_nx       = chon;
        underrun_nx   = underrun;
        adv_nx        = 1'b0;
        flag_end_nx   = 1'b0;
        finish        = 1'b0;

        case (state)
            LOAD: begin
                if (got) begin
                    cur_nx       = rom_data;
                    cur_end_nx   = byte_is_end;
                    cur_valid_nx = 1'b1;
                    rom_cs_nx    = 1'b0;
                    chon_nx      = 1'b1;
                    state_nx     = PLAY;
                end else if (!rom_cs) begin
                    rom_cs_nx = 1'b1;
                end
            end
            PLAY: begin
                phase_nx = acc_sum[15:0];
                if (adv) begin
                    if (!nib) begin
                        nib_nx = 1'b1;
                    end else if (cur_end && !repeat_en) begin
                        finish       = 1'b1;
                        state_nx     = IDLE;
                        chon_nx      = 1'b0;
                        flag_end_nx  = 1'b1;
                        rom_cs_nx    = 1'b0;
                        cur_valid_nx = 1'b0;
                        nxt_valid_nx = 1'b0;
                    end else if (nxt_valid) begin
                        cur_nx       = nxt;
                        cur_end_nx   = nxt_end;
                        nxt_valid_nx = 1'b0;
                        nib_nx       = 1'b0;
                    end else begin
                        // Starved: keep showing the consumed nibble until the byte lands.
                        cur_valid_nx = 1'b0;
                    end
                end
                if (!finish) begin
                    if (got) begin
                        rom_cs_nx = 1'b0;
                        if (!cur_valid_nx) begin
                            cur_nx       = rom_data;
                            cur_end_nx   = byte_is_end;
                            cur_valid_nx = 1'b1;
                            nib_nx       = 1'b0;
                        end else begin
                            nxt_nx       = rom_data;
                            nxt_end_nx   = byte_is_end;
                            nxt_valid_nx = 1'b1;
                        end
                    end else if (!rom_cs && !fetch_stop && !nxt_valid_nx) begin
                        rom_cs_nx     = 1'b1;
                        rom_addr_nx   = ptr;
                        ptr_nx        = ptr_inc;
                        fetch_stop_nx = (ptr == end_byte) && !repeat_en;
                    end
                    // A carry with nothing to hand out is dropped, not queued.
                    adv_nx      = acc_sum[16] & cur_valid_nx;
                    underrun_nx = underrun | (acc_sum[16] & ~cur_valid_nx);
                end
            end
            default: ;
        endcase

        if (stop) begin
            state_nx     = IDLE;
            rom_cs_nx    = 1'b0;
            chon_nx      = 1'b0;
            adv_nx       = 1'b0;
            flag_end_nx  = 1'b0;
            cur_valid_nx = 1'b0;
            nxt_valid_nx = 1'b0;
        end else if (start) begin
            // rom_cs is dropped for one cen so a stale rom_ok cannot complete the new request.
            state_nx      = LOAD;
            rom_cs_nx     = 1'b0;
            rom_addr_nx   = start_byte;
            ptr_nx        = (start_byte == end_byte) ? start_byte : start_byte + AW'(1);
            fetch_stop_nx = (start_byte == end_byte) && !repeat_en;
            nib_nx        = 1'b0;
            phase_nx      = 16'h0000;
            cur_valid_nx  = 1'b0;
            nxt_valid_nx  = 1'b0;
            chon_nx       = 1'b0;
            adv_nx        = 1'b0;
            flag_end_nx   = 1'b0;
            underrun_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            rom_addr   <= '0;
            rom_cs     <= 1'b0;
            cur        <= 8'h00;
            nxt        <= 8'h00;
            cur_valid  <= 1'b0;
            nxt_valid  <= 1'b0;
            cur_end    <= 1'b0;
            nxt_end    <= 1'b0;
            nib        <= 1'b0;
            phase      <= 16'h0000;
            fetch_stop <= 1'b0;
            chon       <= 1'b0;
            underrun   <= 1'b0;
            adv        <= 1'b0;
            flag_end   <= 1'b0;
        end else if (cen) begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            rom_addr   <= rom_addr_nx;
            rom_cs     <= rom_cs_nx;
            cur        <= cur_nx;
            nxt        <= nxt_nx;
            cur_valid  <= cur_valid_nx;
            nxt_valid  <= nxt_valid_nx;
            cur_end    <= cur_end_nx;
            nxt_end    <= nxt_end_nx;
            nib        <= nib_nx;
            phase      <= phase_nx;
            fetch_stop <= fetch_stop_nx;
            chon       <= chon_nx;
            underrun   <= underrun_nx;
            adv        <= adv_nx;
            flag_end   <= flag_end_nx;
        end
    end

endmodule

// File: tb/tb_jt10_adpcmb_fetch.sv
// Directed bench for jt10_adpcmb_fetch: behavioural ROM with programmable latency, nibble
// sequence and adv pacing checked against bench-computed values.
module tb_jt10_adpcmb_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        repeat_en = 1'b0;
    logic [15:0] start_page = 16'h0001;
    logic [15:0] end_page = 16'h0001;
    logic [15:0] delta_n = 16'h8000;
    logic [23:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_ok = 1'b0;
    logic [3:0]  data;
    logic        adv;
    logic        chon;
    logic        flag_end;
    logic        underrun;

    int checks = 0;
    int failures = 0;

    int rom_lat = 0;
    int wait_cnt = 0;
    logic late_ok = 1'b0;
    logic pre_cs;

    int adv_cnt, nib_err, spacing_err, flag_cnt, flag_chon_err, cs_seen, since, nib_idx;
    int carry_cnt;
    logic [15:0] tb_acc;
    logic [23:0] first_addr;
    logic first_set, prev_chon, prev_cs;
    logic [3:0] wrap_data;

    always #5 clk = ~clk;

    jt10_adpcmb_fetch #(.AW(24)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .stop(stop),
        .repeat_en(repeat_en), .start_page(start_page), .end_page(end_page),
        .delta_n(delta_n), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
        .rom_ok(rom_ok), .data(data), .adv(adv), .chon(chon), .flag_end(flag_end),
        .underrun(underrun)
    );

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [3:0] exp_nib(input int idx);
        logic [7:0] b;
        b = rom_byte(24'h000100 + 24'((idx / 2) % 256));
        return (idx % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        adv_cnt = 0; nib_err = 0; spacing_err = 0; flag_cnt = 0; flag_chon_err = 0;
        cs_seen = 0; since = 0; nib_idx = 0; carry_cnt = 0; tb_acc = 16'h0000;
        first_set = 1'b0; first_addr = 24'h0; prev_chon = chon; prev_cs = rom_cs;
        wrap_data = 4'h0;
    endtask

    // One cen edge followed by one gap clock with cen low.
    task automatic step();
        logic [16:0] s;
        if (rom_cs) begin
            rom_ok   = (wait_cnt >= rom_lat);
            rom_data = rom_byte(rom_addr);
        end else begin
            rom_ok = late_ok;
        end
        if (chon && !stop && !start) begin
            s = {1'b0, tb_acc} + {1'b0, delta_n};
            tb_acc = s[15:0];
            if (s[16]) carry_cnt++;
        end
        pre_cs = rom_cs;
        cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
        if (pre_cs && !rom_ok) wait_cnt++;
        else wait_cnt = 0;
        rom_ok = 1'b0;
        if (rom_cs && !prev_cs && !first_set) begin
            first_addr = rom_addr;
            first_set  = 1'b1;
        end
        prev_cs = rom_cs;
        if (rom_cs) cs_seen++;
        since++;
        if (adv) begin
            if (data !== exp_nib(nib_idx)) nib_err++;
            nib_idx++;
            adv_cnt++;
            if (adv_cnt == 513) wrap_data = data;
            if (adv_cnt > 1 && since != 2) spacing_err++;
            since = 0;
        end
        if (flag_end) begin
            flag_cnt++;
            if (chon || !prev_chon) flag_chon_err++;
        end
        prev_chon = chon;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        logic [7:0] b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chon", 32'(chon), 0);
        chk("rst_rom_cs", 32'(rom_cs), 0);
        chk("rst_adv", 32'(adv), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_flag_end", 32'(flag_end), 0);
        #2 rst_n = 1'b1;
        repeat (2) step();

        // One page, instant ROM, half-rate adv, no repeat.
        clr_mon();
        pulse_start();
        for (int i = 0; i < 1300 && flag_cnt == 0; i++) step();
        repeat (6) step();
        chk("s1_first_addr", 32'(first_addr), 32'h000100);
        chk("s1_adv_count", 32'(adv_cnt), 512);
        chk("s1_nibble_errors", 32'(nib_err), 0);
        chk("s1_flag_count", 32'(flag_cnt), 1);
        chk("s1_flag_chon_edge", 32'(flag_chon_err), 0);
        chk("s1_adv_spacing", 32'(spacing_err), 0);
        chk("s1_underrun", 32'(underrun), 0);
        chk("s1_chon_after", 32'(chon), 0);

        // Same with repeat: seamless wrap back to the start byte.
        repeat_en = 1'b1;
        clr_mon();
        pulse_start();
        for (int i = 0; i < 1300 && adv_cnt < 520; i++) step();
        b0 = rom_byte(24'h000100);
        chk("s2_adv_count", 32'(adv_cnt), 520);
        chk("s2_wrap_nibble", 32'(wrap_data), 32'(b0[7:4]));
        chk("s2_nibble_errors", 32'(nib_err), 0);
        chk("s2_adv_spacing", 32'(spacing_err), 0);
        chk("s2_no_flag", 32'(flag_cnt), 0);
        chk("s2_chon", 32'(chon), 1);
        pulse_stop();
        chk("s2_stop_chon", 32'(chon), 0);
        chk("s2_stop_rom_cs", 32'(rom_cs), 0);
        chk("s2_stop_adv", 32'(adv), 0);
        chk("s2_stop_no_flag", 32'(flag_end), 0);

        // Fast rate against slow ROM: starvation.
        repeat_en = 1'b0;
        delta_n = 16'hFFFF;
        rom_lat = 8;
        clr_mon();
        pulse_start();
        repeat (300) step();
        chk("s3_underrun", 32'(underrun), 1);
        chk("s3_adv_lt_carry", 32'(adv_cnt < carry_cnt), 1);
        chk("s3_adv_some", 32'(adv_cnt > 20), 1);
        chk("s3_nibble_errors", 32'(nib_err), 0);
        pulse_stop();

        // Abort during an outstanding request; late rom_ok must be ignored.
        delta_n = 16'h8000;
        rom_lat = 50;
        clr_mon();
        pulse_start();
        repeat (3) step();
        chk("s4_cs_pending", 32'(rom_cs), 1);
        pulse_stop();
        chk("s4_stop_rom_cs", 32'(rom_cs), 0);
        chk("s4_stop_chon", 32'(chon), 0);
        clr_mon();
        late_ok = 1'b1;
        repeat (3) step();
        late_ok = 1'b0;
        repeat (2) step();
        chk("s4_late_cs", 32'(cs_seen), 0);
        chk("s4_late_chon", 32'(chon), 0);
        chk("s4_no_flag", 32'(flag_cnt), 0);

        // start and stop together in IDLE.
        rom_lat = 0;
        clr_mon();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        repeat (5) step();
        chk("s5_cs_never", 32'(cs_seen), 0);
        chk("s5_chon", 32'(chon), 0);

        // Asynchronous reset mid-play, then replay.
        clr_mon();
        pulse_start();
        repeat (100) step();
        chk("s6_playing", 32'(chon), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_chon", 32'(chon), 0);
        chk("s6_rst_rom_cs", 32'(rom_cs), 0);
        chk("s6_rst_adv", 32'(adv), 0);
        chk("s6_rst_rom_addr", 32'(rom_addr), 0);
        chk("s6_rst_data", 32'(data), 0);
        #20 rst_n = 1'b1;
        wait_cnt = 0;
        clr_mon();
        pulse_start();
        repeat (40) step();
        chk("s6_replay_addr", 32'(first_addr), 32'h000100);
        chk("s6_replay_chon", 32'(chon), 1);
        chk("s6_replay_nibbles", 32'(nib_err), 0);
        chk("s6_replay_advs", 32'(adv_cnt > 10), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
